// File: rtl/fetch_unit.sv
// Instruction fetch stage: BRAM word-read port, PC tracking, redirect/squash and a
// valid/ready hand-off to decode. Define FETCH_ALIGN_CHECK_EN to trap misaligned redirects.
module fetch_unit #(
    parameter int unsigned     XLEN        = 64,
    parameter int unsigned     ADDR_W      = 14,
    parameter int unsigned     MEM_LATENCY = 1,
    parameter logic [XLEN-1:0] RESET_PC    = '0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    output logic              o_mem_read,
    output logic [ADDR_W-1:0] o_mem_address,
    input  logic [31:0]       i_mem_value,
    output logic              o_insn_valid,
    input  logic              i_insn_ready,
    output logic [31:0]       o_insn,
    output logic [XLEN-1:0]   o_insn_pc,
    input  logic              i_redirect,
    input  logic [XLEN-1:0]   i_redirect_pc,
    output logic [XLEN-1:0]   o_pc,
    output logic              o_fault
);

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
`ifdef FETCH_ALIGN_CHECK_EN
    localparam logic [1:0] ST_FAULT = 2'd3;
`endif

    localparam logic [3:0]      CNT_INIT  = 4'(MEM_LATENCY - 1);
    localparam logic [XLEN-1:0] WORD_MASK = ~{{(XLEN-2){1'b0}}, 2'b11};

    logic [1:0]      state;
    logic [XLEN-1:0] pc;
    logic [3:0]      cnt;
    logic            take_redirect;

`ifdef FETCH_ALIGN_CHECK_EN
    // Once trapped, redirects are ignored; only reset leaves FAULT.
    assign take_redirect = i_redirect && (state != ST_FAULT);
`else
    assign take_redirect = i_redirect;
    assign o_fault       = 1'b0;
`endif

    assign o_pc = pc;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state         <= ST_FETCH;
            pc            <= RESET_PC;
            cnt           <= '0;
            o_mem_read    <= 1'b0;
            o_mem_address <= '0;
            o_insn_valid  <= 1'b0;
            o_insn        <= '0;
            o_insn_pc     <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
            o_fault       <= 1'b0;
`endif
        end else if (take_redirect) begin
            // Squash: the pending read is simply never captured.
            o_mem_read   <= 1'b0;
            o_insn_valid <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            if (i_redirect_pc[1:0] != 2'b00) begin
                state   <= ST_FAULT;
                o_fault <= 1'b1;
            end else begin
                pc    <= i_redirect_pc & WORD_MASK;
                state <= ST_FETCH;
            end
`else
            pc    <= i_redirect_pc & WORD_MASK;
            state <= ST_FETCH;
`endif
        end else begin
            case (state)
                ST_FETCH: begin
                    o_mem_address <= pc[ADDR_W+1:2];
                    o_mem_read    <= 1'b1;
                    o_insn_pc     <= pc;
                    pc            <= pc + XLEN'(4);
                    cnt           <= CNT_INIT;
                    state         <= ST_WAIT;
                end
                ST_WAIT: begin
                    o_mem_read <= 1'b0;
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        o_insn       <= i_mem_value;
                        o_insn_valid <= 1'b1;
                        state        <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (i_insn_ready) begin
                        o_insn_valid <= 1'b0;
                        state        <= ST_FETCH;
                    end
                end
                default: begin
                    o_mem_read   <= 1'b0;
                    o_insn_valid <= 1'b0;
`ifndef FETCH_ALIGN_CHECK_EN
                    state        <= ST_FETCH;
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: two instances (latency 1 and 3) share random stimulus
// and are compared each cycle against a per-instance timeline model of the fetch sequence.
module tb_fetch_unit;

    localparam int unsigned NI     = 2;
    localparam int unsigned NCYC   = 900;
    localparam int unsigned MWORDS = 16384;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ready = 1'b0;
    logic        redirect = 1'b0;
    logic [63:0] redirect_pc = '0;

    logic        mem_read    [NI];
    logic [13:0] mem_address [NI];
    logic [31:0] mem_value   [NI];
    logic        insn_valid  [NI];
    logic [31:0] insn        [NI];
    logic [63:0] insn_pc     [NI];
    logic [63:0] pc          [NI];
    logic        fault       [NI];

    fetch_unit #(.XLEN(64), .ADDR_W(14), .MEM_LATENCY(1), .RESET_PC(64'h0)) u_fetch_l1 (
        .i_clk(clk), .i_reset(reset),
        .o_mem_read(mem_read[0]), .o_mem_address(mem_address[0]), .i_mem_value(mem_value[0]),
        .o_insn_valid(insn_valid[0]), .i_insn_ready(ready), .o_insn(insn[0]), .o_insn_pc(insn_pc[0]),
        .i_redirect(redirect), .i_redirect_pc(redirect_pc), .o_pc(pc[0]), .o_fault(fault[0])
    );

    fetch_unit #(.XLEN(64), .ADDR_W(14), .MEM_LATENCY(3), .RESET_PC(64'h100)) u_fetch_l3 (
        .i_clk(clk), .i_reset(reset),
        .o_mem_read(mem_read[1]), .o_mem_address(mem_address[1]), .i_mem_value(mem_value[1]),
        .o_insn_valid(insn_valid[1]), .i_insn_ready(ready), .o_insn(insn[1]), .o_insn_pc(insn_pc[1]),
        .i_redirect(redirect), .i_redirect_pc(redirect_pc), .o_pc(pc[1]), .o_fault(fault[1])
    );

    always #5 clk = ~clk;

    function automatic int unsigned lat_of(input int unsigned k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic logic [63:0] rst_pc_of(input int unsigned k);
        return (k == 0) ? 64'h0 : 64'h100;
    endfunction

    logic [31:0] mem [0:MWORDS-1];

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Model: t = cycles since the current fetch began (0 = fetch cycle), fpc = its PC.
    int unsigned t       [NI];
    logic [63:0] fpc     [NI];
    bit          faulted [NI];
    int unsigned age     [NI];
    logic [13:0] paddr   [NI];
    bit          rst_prev;

    initial begin
        string       p;
        int unsigned lat;
        int unsigned run;
        bit          rdy_val;
        bit          done40, done42, donewrap, donersth, donerstw;
        logic [63:0] rpc;

        for (int i = 0; i < MWORDS; i++) mem[i] = $urandom;
        for (int k = 0; k < NI; k++) begin
            t[k] = 0; fpc[k] = rst_pc_of(k); faulted[k] = 1'b0;
            age[k] = 0; paddr[k] = '0; mem_value[k] = '0;
        end
        rst_prev = 1'b1;
        run = 0; rdy_val = 1'b1;
        done40 = 0; done42 = 0; donewrap = 0; donersth = 0; donerstw = 0;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);

            for (int unsigned k = 0; k < NI; k++) begin
                lat = lat_of(k);
                p = $sformatf("u%0d c%0d", k, cyc);
                if (rst_prev) begin
                    check({p, " rst insn"}, 64'(insn[k]), 64'h0);
                    check({p, " rst insn_pc"}, insn_pc[k], 64'h0);
                    check({p, " rst mem_address"}, 64'(mem_address[k]), 64'h0);
                end
                check({p, " insn_valid"}, 64'(insn_valid[k]), 64'(!faulted[k] && t[k] >= lat + 1));
                check({p, " mem_read"}, 64'(mem_read[k]), 64'(!faulted[k] && t[k] == 1));
                check({p, " fault"}, 64'(fault[k]), 64'(faulted[k]));
                if (!faulted[k])
                    check({p, " pc"}, pc[k], (t[k] == 0) ? fpc[k] : fpc[k] + 64'd4);
                if (!faulted[k] && t[k] == 1)
                    check({p, " mem_address"}, 64'(mem_address[k]), 64'(fpc[k][15:2]));
                if (!faulted[k] && t[k] >= lat + 1) begin
                    check({p, " insn"}, 64'(insn[k]), 64'(mem[fpc[k][15:2]]));
                    check({p, " insn_pc"}, insn_pc[k], fpc[k]);
                end

                // Memory: data is presented only in the cycle it is due, garbage otherwise.
                if (mem_read[k] === 1'b1) begin
                    paddr[k] = mem_address[k];
                    age[k] = 1;
                end else if (age[k] != 0 && age[k] < 1000) begin
                    age[k]++;
                end
                mem_value[k] = (age[k] == lat) ? mem[paddr[k]] : $urandom;
            end

            reset = 1'b0;
            redirect = 1'b0;
            redirect_pc = 64'($urandom);
            if (cyc < 2) begin
                reset = 1'b1;
            end else if (cyc >= 30 && !done40 && t[1] == 2) begin
                redirect = 1'b1; redirect_pc = 64'h40; done40 = 1;
            end else if (cyc >= 50 && !done42 && t[0] == 1) begin
                redirect = 1'b1; redirect_pc = 64'h42; done42 = 1;
            end else if (cyc >= 70 && !donewrap && t[0] >= 2) begin
                redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC; donewrap = 1;
            end else if ((cyc >= 90 && !donersth && t[0] >= 2) || (cyc == 105 && !donersth)) begin
                reset = 1'b1; donersth = 1;
            end else if ((cyc >= 110 && !donerstw && t[1] == 1) || (cyc == 125 && !donerstw)) begin
                reset = 1'b1; donerstw = 1;
            end else if (cyc >= 130) begin
                if ($urandom_range(0, 79) == 0) begin
                    reset = 1'b1;
                end else if ($urandom_range(0, 19) == 0) begin
                    redirect = 1'b1;
                    case ($urandom_range(0, 2))
                        0: rpc = 64'($urandom_range(0, 255));
                        1: rpc = {$urandom, $urandom};
                        default: rpc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
                    endcase
                    redirect_pc = rpc;
                end
            end

            if (cyc < 30) begin
                ready = 1'b1;
            end else begin
                if (run == 0) begin
                    rdy_val = 1'($urandom_range(0, 1));
                    run = $urandom_range(1, 7);
                end
                run--;
                ready = rdy_val;
            end

            for (int unsigned k = 0; k < NI; k++) begin
                lat = lat_of(k);
                if (reset) begin
                    t[k] = 0; fpc[k] = rst_pc_of(k); faulted[k] = 1'b0;
                end else if (faulted[k]) begin
                    t[k] = t[k];
                end else if (redirect) begin
`ifdef FETCH_ALIGN_CHECK_EN
                    if (redirect_pc[1:0] != 2'b00) begin
                        faulted[k] = 1'b1;
                    end else begin
                        t[k] = 0; fpc[k] = redirect_pc;
                    end
`else
                    t[k] = 0;
                    fpc[k] = {redirect_pc[63:2], 2'b00};
`endif
                end else if (t[k] >= lat + 1 && ready) begin
                    t[k] = 0;
                    fpc[k] = fpc[k] + 64'd4;
                end else if (t[k] < lat + 1) begin
                    t[k]++;
                end
            end
            rst_prev = reset;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
